// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port-0 arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic              we;
    logic [MASK_W-1:0] wmask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant. The pointer remembers who was served last and
// only moves when a grant (which is always a transfer) is issued.
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = B has priority on a tie; reset gives A priority.
  logic prio_b_q;
  logic prio_b_d;

  // Grant selection and pointer update; no grants while reset is asserted.
  always_comb begin
    gnt      = 2'b00;
    prio_b_d = prio_b_q;
    if (rst_n) begin
      if (req[0] && req[1]) begin
        gnt = prio_b_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0]) begin
      prio_b_d = 1'b1;
    end else if (gnt[1]) begin
      prio_b_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between requesters A and B. Accepted requests are
// registered straight onto the macro pins; reads are tagged and the data is
// steered back to the issuing requester RD_LAT edges after acceptance.
import sram_arb_pkg::*;

module sram_port_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [MASK_W-1:0] a_wmask,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [MASK_W-1:0] b_wmask,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [MASK_W-1:0] sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              busy
);

  logic [1:0] gnt;
  sram_req_t  a_req;
  sram_req_t  b_req;
  sram_req_t  sel_req;
  req_id_t    sel_id;
  logic       xfer;

  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  rd_tag_t [RD_LAT-1:0] pipe_q, pipe_d;
  rd_tag_t              head;

  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              busy_c;

  sram_rr_arbiter u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_valid, a_valid}),
    .gnt   (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign a_req   = {a_we, a_wmask, a_addr, a_wdata};
  assign b_req   = {b_we, b_wmask, b_addr, b_wdata};

  // Payload mux and next values for the macro pins and the return pipeline.
  always_comb begin
    xfer    = |gnt;
    sel_req = gnt[1] ? b_req : a_req;
    sel_id  = gnt[1] ? REQ_B : REQ_A;

    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    if (xfer) begin
      csb_d   = 1'b0;
      web_d   = ~sel_req.we;
      wmask_d = sel_req.we ? sel_req.wmask : '0;
      addr_d  = sel_req.addr;
      din_d   = sel_req.wdata;
    end

    pipe_d[0].valid = xfer && !sel_req.we;
    pipe_d[0].id    = sel_id;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    head       = pipe_q[RD_LAT-1];
    a_rvalid_d = head.valid && (head.id == REQ_A);
    b_rvalid_d = head.valid && (head.id == REQ_B);
    a_rdata_d  = a_rvalid_d ? sram_dout0 : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? sram_dout0 : b_rdata_q;

    busy_c = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      busy_c = busy_c | pipe_q[i].valid;
    end
  end

  // Macro pin registers, return pipeline and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      pipe_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      pipe_q     <= pipe_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign busy        = busy_c;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural macro, reference memory with an
// expected-response queue, and one task per scenario.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          cyc;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [3:0]  a_wmask = '0;
  logic [8:0]  a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [3:0]  b_wmask = '0;
  logic [8:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        sram_csb0, sram_web0, busy;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  ret_t ret_q[$];
  ret_t exp_q[$];
  bit   acc_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sram_port_arbiter #(.RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port macro: registered read, masked write.
  always @(posedge clk) begin
    if (sram_csb0 === 1'b0) begin
      if (sram_web0 === 1'b0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  // Reference model: applies each accepted transfer to ref_mem in accept order.
  task automatic note_accept(input bit id, input logic we, input logic [3:0] m,
                             input logic [8:0] ad, input logic [31:0] d);
    acc_q.push_back(id);
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[ad][8*i +: 8] = d[8*i +: 8];
    end else begin
      exp_q.push_back('{id, ref_mem[ad], cyc + 1 + LAT});
    end
  endtask

  // Observe responses and transfers mid-cycle.
  always @(negedge clk) begin
    if (a_rvalid === 1'b1) ret_q.push_back('{1'b0, a_rdata, cyc});
    if (b_rvalid === 1'b1) ret_q.push_back('{1'b1, b_rdata, cyc});
    if (a_valid && a_ready === 1'b1) note_accept(1'b0, a_we, a_wmask, a_addr, a_wdata);
    if (b_valid && b_ready === 1'b1) note_accept(1'b1, b_we, b_wmask, b_addr, b_wdata);
  end

  task automatic drv_a(input bit v, input bit we, input logic [3:0] m,
                       input logic [8:0] ad, input logic [31:0] d);
    a_valid = v; a_we = we; a_wmask = m; a_addr = ad; a_wdata = d;
  endtask

  task automatic drv_b(input bit v, input bit we, input logic [3:0] m,
                       input logic [8:0] ad, input logic [31:0] d);
    b_valid = v; b_we = we; b_wmask = m; b_addr = ad; b_wdata = d;
  endtask

  task automatic clear_logs();
    ret_q.delete(); exp_q.delete(); acc_q.delete();
  endtask

  task automatic preload(input logic [8:0] ad, input logic [31:0] d);
    mem[ad] = d;
    ref_mem[ad] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv_a(1, 0, 0, 9'h011, 0); drv_b(1, 0, 0, 9'h022, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready cyc%0d got %b want 0", k, a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready cyc%0d got %b want 0", k, b_ready); end
      checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL reset_csb0 cyc%0d got %b want 1", k, sram_csb0); end
      checks++; if (sram_web0 !== 1'b1) begin errors++; $display("FAIL reset_web0 cyc%0d got %b want 1", k, sram_web0); end
      checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid cyc%0d got a=%b b=%b want 0", k, a_rvalid, b_rvalid); end
    end
    checks++; if (sram_addr0 !== 9'h0 || sram_din0 !== 32'h0 || sram_wmask0 !== 4'h0) begin
      errors++; $display("FAIL reset_pins got addr=%h din=%h wmask=%h want 0", sram_addr0, sram_din0, sram_wmask0);
    end
    checks++; if (busy !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL reset_busy_rdata got busy=%b rdata=%h want 0", busy, a_rdata); end
    @(posedge clk); #1;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_read();
    int acc_cyc;
    preload(9'h1FF, 32'hDEADBEEF);
    clear_logs();
    @(posedge clk); #1 drv_a(1, 0, 0, 9'h1FF, 0);
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", a_ready); end
    acc_cyc = cyc + 1;
    @(posedge clk); #1 drv_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h1FF) begin
      errors++; $display("FAIL single_issue got csb=%b web=%b addr=%h want 0 1 1ff", sram_csb0, sram_web0, sram_addr0);
    end
    @(negedge clk);
    checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL single_csb_pulse got %b want 1", sram_csb0); end
    repeat (4) @(negedge clk);
    checks++; if (ret_q.size() !== 1) begin errors++; $display("FAIL single_ret_count got %0d want 1", ret_q.size()); end
    if (ret_q.size() >= 1) begin
      checks++; if (ret_q[0].id !== 1'b0 || ret_q[0].data !== 32'hDEADBEEF || ret_q[0].cyc !== acc_cyc + 2) begin
        errors++; $display("FAIL single_ret got id=%0d data=%h cyc=%0d want id=0 data=deadbeef cyc=%0d",
                           ret_q[0].id, ret_q[0].data, ret_q[0].cyc, acc_cyc + 2);
      end
    end
  endtask

  task automatic test_contention();
    int na, nb;
    bit sa, sb;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      preload(9'h010 + 9'(i), 32'hA0000000 + 32'(i));
      preload(9'h020 + 9'(i), 32'hB0000000 + 32'(i));
    end
    na = 0; nb = 0;
    drv_a(1, 0, 0, 9'h010, 0); drv_b(1, 0, 0, 9'h020, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sa = a_ready; sb = b_ready;
      checks++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
        errors++; $display("FAIL contention_grant k=%0d got a=%b b=%b want a=%0d", k, a_ready, b_ready, (k % 2 == 0));
      end
      @(posedge clk); #1;
      if (sa) begin na++; a_addr = 9'h010 + 9'(na); end
      if (sb) begin nb++; b_addr = 9'h020 + 9'(nb); end
    end
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL contention_accepts got %0d want 4", acc_q.size()); end
    checks++; if (ret_q.size() !== 4) begin errors++; $display("FAIL contention_ret_count got %0d want 4", ret_q.size()); end
    for (int i = 0; i < ret_q.size() && i < 4; i++) begin
      logic [31:0] want;
      want = (i % 2 == 0) ? 32'hA0000000 + 32'(i / 2) : 32'hB0000000 + 32'(i / 2);
      checks++; if (ret_q[i].id !== bit'(i % 2) || ret_q[i].data !== want ||
                    (i > 0 && ret_q[i].cyc !== ret_q[i-1].cyc + 1)) begin
        errors++; $display("FAIL contention_ret%0d got id=%0d data=%h cyc=%0d want id=%0d data=%h",
                           i, ret_q[i].id, ret_q[i].data, ret_q[i].cyc, i % 2, want);
      end
    end
  endtask

  task automatic test_masked_write();
    preload(9'h005, 32'hAAAAAAAA);
    clear_logs();
    @(posedge clk); #1 drv_b(1, 1, 4'b0101, 9'h005, 32'h11223344);
    @(negedge clk);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL mwrite_ready got %b want 1", b_ready); end
    @(posedge clk); #1;
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 9'h005, 0);
    @(negedge clk);
    checks++; if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 4'b0101 || sram_din0 !== 32'h11223344) begin
      errors++; $display("FAIL mwrite_issue got csb=%b web=%b wmask=%b din=%h want 0 0 0101 11223344",
                         sram_csb0, sram_web0, sram_wmask0, sram_din0);
    end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mwrite_read_ready got %b want 1", a_ready); end
    @(posedge clk); #1 drv_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (sram_wmask0 !== 4'b0000 || sram_web0 !== 1'b1) begin
      errors++; $display("FAIL mread_pins got wmask=%b web=%b want 0000 1", sram_wmask0, sram_web0);
    end
    repeat (4) @(negedge clk);
    checks++; if (ret_q.size() !== 1) begin errors++; $display("FAIL mwrite_ret_count got %0d want 1", ret_q.size()); end
    if (ret_q.size() >= 1) begin
      checks++; if (ret_q[0].id !== 1'b0 || ret_q[0].data !== 32'hAA22AA44) begin
        errors++; $display("FAIL mwrite_data got id=%0d data=%h want id=0 data=aa22aa44", ret_q[0].id, ret_q[0].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [8];
    int n, accepts;
    bit sa;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      preload(9'h040 + 9'(i), d[i]);
    end
    clear_logs();
    n = 0; accepts = 0;
    @(posedge clk); #1 drv_a(1, 0, 0, 9'h040, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sa = a_ready;
      if (sa) accepts++;
      @(posedge clk); #1;
      if (sa) n++;
      if (n < 8) a_addr = 9'h040 + 9'(n);
      else drv_a(0, 0, 0, 0, 0);
    end
    drv_a(0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    checks++; if (accepts !== 8) begin errors++; $display("FAIL b2b_accepts got %0d want 8", accepts); end
    checks++; if (ret_q.size() !== 8) begin errors++; $display("FAIL b2b_ret_count got %0d want 8", ret_q.size()); end
    for (int i = 0; i < ret_q.size() && i < 8; i++) begin
      checks++; if (ret_q[i].id !== 1'b0 || ret_q[i].data !== d[i] || ret_q[i].cyc !== ret_q[0].cyc + i) begin
        errors++; $display("FAIL b2b_ret%0d got id=%0d data=%h cyc=%0d want id=0 data=%h cyc=%0d",
                           i, ret_q[i].id, ret_q[i].data, ret_q[i].cyc, d[i], ret_q[0].cyc + i);
      end
    end
    if (ret_q.size() >= 1 && exp_q.size() >= 1) begin
      checks++; if (ret_q[0].cyc !== exp_q[0].cyc) begin
        errors++; $display("FAIL b2b_latency got cyc=%0d want %0d", ret_q[0].cyc, exp_q[0].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    preload(9'h030, 32'h13572468);
    clear_logs();
    @(posedge clk); #1 drv_a(1, 0, 0, 9'h030, 0);
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", a_ready); end
    @(posedge clk); #1;
    drv_a(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_inflight got %b want 1", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (ret_q.size() !== 0) begin errors++; $display("FAIL midrst_no_rvalid got %0d responses want 0", ret_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    clear_logs();
  endtask

  task automatic test_random();
    bit last_b, sa, sb, ea, eb;
    do_reset();
    last_b = 1'b1;
    sa = 1'b0; sb = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (sa) a_valid = 1'b0;
      if (sb) b_valid = 1'b0;
      if (!a_valid && $urandom_range(1, 0) == 1)
        drv_a(1, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 9'($urandom_range(15, 0)), $urandom);
      if (!b_valid && $urandom_range(1, 0) == 1)
        drv_b(1, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 9'($urandom_range(15, 0)), $urandom);
      @(negedge clk);
      ea = a_valid && (!b_valid || last_b);
      eb = b_valid && (!a_valid || !last_b);
      checks++; if (a_ready !== ea || b_ready !== eb) begin
        errors++; $display("FAIL rand_grant k=%0d got a=%b b=%b want a=%b b=%b", k, a_ready, b_ready, ea, eb);
      end
      if (ea) last_b = 1'b0;
      else if (eb) last_b = 1'b1;
      sa = a_ready; sb = b_ready;
    end
    @(posedge clk); #1;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    checks++; if (ret_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_ret_count got %0d want %0d", ret_q.size(), exp_q.size());
    end
    for (int i = 0; i < ret_q.size() && i < exp_q.size(); i++) begin
      checks++; if (ret_q[i].id !== exp_q[i].id || ret_q[i].data !== exp_q[i].data || ret_q[i].cyc !== exp_q[i].cyc) begin
        errors++; $display("FAIL rand_ret%0d got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d", i,
                           ret_q[i].id, ret_q[i].data, ret_q[i].cyc, exp_q[i].id, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_single_read();
    test_contention();
    test_masked_write();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
